ball_ctl: RTL
=============

Name: ball_ctl

Overview:
Frame-synchronous game controller for the Pong display pipeline. It detects the start of each vertical blank on the timing stream and sequences serve, play and scoring through a state machine. Once per frame it advances the ball position and resolves collisions against the screen edges and both paddles. It drives ball_x/ball_y/ball_en to the downstream ball-drawing stage, so positions change only during blanking and never mid-frame.

Parameters:
H_ACTIVE, 1024, visible pixels per line
V_ACTIVE, 768, visible lines per frame
BALL_SIZE, 16, ball edge length in pixels (square)
STEP, 4, pixels moved per frame on each axis
PADDLE_W, 16, paddle width
PADDLE_H, 128, paddle height
PAD_L_X, 32, left paddle left edge x
PAD_R_X, 976, right paddle left edge x
SERVE_DELAY, 60, frames held in SERVE before play

Ports:
pclk  input  1  pixel clock, all logic on rising edge
rst  input  1  synchronous active-high reset
vblnk_in  input  1  vertical blank from timing chain
start  input  1  level; begins game from IDLE
paddle_l_y  input  11  left paddle top y, sampled on frame tick
paddle_r_y  input  11  right paddle top y, sampled on frame tick
ball_x  output  11  ball left edge x (registered)
ball_y  output  11  ball top edge y (registered)
ball_en  output  1  ball visible (registered)
score_l  output  1  one-cycle pulse: left player scored
score_r  output  1  one-cycle pulse: right player scored
state_out  output  2  IDLE=0, SERVE=1, PLAY=2, SCORED=3

Behaviour:
- Clock is pclk; reset is synchronous and active-high, named rst.
- Reset: state IDLE; ball_x=(H_ACTIVE-BALL_SIZE)/2=504; ball_y=(V_ACTIVE-BALL_SIZE)/2=376; dir_x=right; dir_y=down; ball_en=0; score_l=score_r=0; serve counter=0; vblnk_d=0. Reset mid-game forces all of the above on the next edge.
- Frame tick: vblnk_d <= vblnk_in; tick = vblnk_in & ~vblnk_d. Exactly one tick per blank regardless of blank length.
- Latency: state and position registers update on the edge where tick=1. New values are visible the following cycle.
- IDLE: ball centred, ball_en=0. start=1 -> SERVE, ball_en<=1, counter<=0. start is ignored in every other state.
- SERVE: counter increments on each tick. On the tick where counter==SERVE_DELAY-1 -> PLAY, counter<=0. The ball does not move.
- PLAY, on tick, axes are resolved independently in the same tick (a corner bounce flips both directions).
  - Vertical, down: if ball_y+STEP+BALL_SIZE >= V_ACTIVE, ball_y<=V_ACTIVE-BALL_SIZE and dir_y<=up; else ball_y+=STEP.
  - Vertical, up: if ball_y < STEP, ball_y<=0 and dir_y<=down; else ball_y-=STEP.
  - Overlap test uses pre-update ball_y: L-overlap = (ball_y+BALL_SIZE > paddle_l_y) && (ball_y < paddle_l_y+PADDLE_H). R-overlap is the same with paddle_r_y.
  - Horizontal, left, face crossing: if ball_x >= PAD_L_X+PADDLE_W && ball_x-STEP <= PAD_L_X+PADDLE_W && L-overlap, ball_x<=PAD_L_X+PADDLE_W and dir_x<=right.
  - Horizontal, left, miss: else if ball_x < STEP -> SCORED with score_r pending.
  - Horizontal, left, otherwise: ball_x-=STEP.
  - Horizontal, right, face crossing: if ball_x+BALL_SIZE <= PAD_R_X && ball_x+STEP+BALL_SIZE >= PAD_R_X && R-overlap, ball_x<=PAD_R_X-BALL_SIZE and dir_x<=left.
  - Horizontal, right, miss: else if ball_x+STEP+BALL_SIZE > H_ACTIVE -> SCORED with score_l pending.
  - Horizontal, right, otherwise: ball_x+=STEP.
  - Paddle-face checks apply only when the ball crosses the face this tick. A ball already behind a paddle continues to the edge.
  - Arithmetic uses 12-bit intermediates; no wrap below 0 or above H_ACTIVE/V_ACTIVE.
- SCORED lasts one cycle, not tick-gated.
  - score_l or score_r = 1 for exactly that cycle; never both.
  - Ball recentred (504, 376); dir_x points toward the player who conceded; dir_y=down.
  - Then -> SERVE with counter=0 and ball_en=1.
- state_out mirrors the state register.

Test Plan:
- Reset, then vblnk_in toggled for 3 frames with start=0 -> ball_x=504, ball_y=376, ball_en=0, state_out=0 throughout.
- SERVE_DELAY=2, start=1 -> SERVE. After 2 ticks PLAY with ball still at 504/376; next tick ball_x=508, ball_y=380. vblnk_in held high for 500 cycles produces one step only.
- Top wall: force ball_y=2 moving up -> tick gives ball_y=0, dir down; next tick ball_y=4. Bottom: ball_y=750 down -> ball_y=752, dir up.
- Left paddle hit: paddle_l_y=300, ball_x=50, ball_y=350, moving left -> ball_x=48, dir right; next tick ball_x=52.
- Left miss: paddle_l_y=0, ball_y=600, ball_x=3 moving left -> score_r=1 for exactly one cycle, score_l=0. Ball then at 504/376 heading left, state_out=1.
- Corner plus reset: ball_y=2 up, ball_x=1005 right, paddle_r_y=600 (no overlap) -> score_l pulse, no score_r. Assert rst during PLAY -> next cycle all reset values, IDLE.

Source files
------------

// File: rtl/ball_ctl.sv
// ball_ctl: frame-synchronous Pong game controller.
// It detects the rising edge of vertical blank (one frame tick per blank). It
// sequences IDLE -> SERVE -> PLAY -> SCORED -> SERVE. On each tick in PLAY it
// moves the ball by STEP on both axes and bounces it off the top/bottom walls
// and the inner faces of both paddles. Positions change only on frame ticks,
// so the drawing stage never sees a mid-frame move.
//
// Ports:
//   pclk        pixel clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   vblnk_in    vertical blank from the timing chain
//   start       level; starts a game from IDLE
//   paddle_l_y  left paddle top y, used on frame ticks
//   paddle_r_y  right paddle top y, used on frame ticks
//   ball_x      ball left edge x (registered)
//   ball_y      ball top edge y (registered)
//   ball_en     ball visible (registered)
//   score_l     one-cycle pulse: left player scored
//   score_r     one-cycle pulse: right player scored
//   state_out   IDLE=0, SERVE=1, PLAY=2, SCORED=3
module ball_ctl #(
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int BALL_SIZE   = 16,
  parameter int STEP        = 4,
  parameter int PADDLE_W    = 16,
  parameter int PADDLE_H    = 128,
  parameter int PAD_L_X     = 32,
  parameter int PAD_R_X     = 976,
  parameter int SERVE_DELAY = 60
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        start,
  input  logic [10:0] paddle_l_y,
  input  logic [10:0] paddle_r_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic        ball_en,
  output logic        score_l,
  output logic        score_r,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    PLAY   = 2'd2,
    SCORED = 2'd3
  } state_t;

  localparam logic [11:0] HA    = 12'(H_ACTIVE);
  localparam logic [11:0] VA    = 12'(V_ACTIVE);
  localparam logic [11:0] BS    = 12'(BALL_SIZE);
  localparam logic [11:0] ST    = 12'(STEP);
  localparam logic [11:0] PH    = 12'(PADDLE_H);
  localparam logic [11:0] L_FACE = 12'(PAD_L_X + PADDLE_W);
  localparam logic [11:0] R_FACE = 12'(PAD_R_X);
  localparam logic [10:0] X_CTR = 11'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] Y_CTR = 11'((V_ACTIVE - BALL_SIZE) / 2);
  localparam int          CW    = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CW-1:0] SRV_LAST = CW'(SERVE_DELAY - 1);

  state_t        state_q;
  logic [10:0]   ball_x_q, ball_y_q;
  logic          dir_right_q, dir_down_q;
  logic          ball_en_q, score_l_q, score_r_q;
  logic          vblnk_q;
  logic [CW-1:0] cnt_q;

  logic          tick;
  logic [11:0]   x12, y12, pl12, pr12;
  logic          ovl_l, ovl_r;
  logic [10:0]   ball_x_d, ball_y_d;
  logic          dir_right_d, dir_down_d;
  logic          miss_left, miss_right;

  // Candidate next position for a PLAY tick; both axes resolved independently,
  // so a corner bounce flips both directions in the same tick.
  always_comb begin
    tick  = vblnk_in & ~vblnk_q;
    x12   = {1'b0, ball_x_q};
    y12   = {1'b0, ball_y_q};
    pl12  = {1'b0, paddle_l_y};
    pr12  = {1'b0, paddle_r_y};
    ovl_l = (y12 + BS > pl12) && (y12 < pl12 + PH);
    ovl_r = (y12 + BS > pr12) && (y12 < pr12 + PH);

    ball_y_d   = ball_y_q;
    dir_down_d = dir_down_q;
    if (dir_down_q) begin
      if (y12 + ST + BS >= VA) begin
        ball_y_d   = 11'(VA - BS);
        dir_down_d = 1'b0;
      end else begin
        ball_y_d = 11'(y12 + ST);
      end
    end else begin
      if (y12 < ST) begin
        ball_y_d   = '0;
        dir_down_d = 1'b1;
      end else begin
        ball_y_d = 11'(y12 - ST);
      end
    end

    // Paddle faces only reflect a ball that crosses them this tick; a ball
    // already behind a paddle keeps going until it leaves the screen.
    ball_x_d    = ball_x_q;
    dir_right_d = dir_right_q;
    miss_left   = 1'b0;
    miss_right  = 1'b0;
    if (!dir_right_q) begin
      if (x12 >= L_FACE && x12 - ST <= L_FACE && ovl_l) begin
        ball_x_d    = 11'(L_FACE);
        dir_right_d = 1'b1;
      end else if (x12 < ST) begin
        miss_left = 1'b1;
      end else begin
        ball_x_d = 11'(x12 - ST);
      end
    end else begin
      if (x12 + BS <= R_FACE && x12 + ST + BS >= R_FACE && ovl_r) begin
        ball_x_d    = 11'(R_FACE - BS);
        dir_right_d = 1'b0;
      end else if (x12 + ST + BS > HA) begin
        miss_right = 1'b1;
      end else begin
        ball_x_d = 11'(x12 + ST);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= IDLE;
      ball_x_q    <= X_CTR;
      ball_y_q    <= Y_CTR;
      dir_right_q <= 1'b1;
      dir_down_q  <= 1'b1;
      ball_en_q   <= 1'b0;
      score_l_q   <= 1'b0;
      score_r_q   <= 1'b0;
      cnt_q       <= '0;
      vblnk_q     <= 1'b0;
    end else begin
      vblnk_q   <= vblnk_in;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SERVE;
            ball_en_q <= 1'b1;
            cnt_q     <= '0;
          end
        end
        SERVE: begin
          if (tick) begin
            if (cnt_q == SRV_LAST) begin
              state_q <= PLAY;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        PLAY: begin
          if (tick) begin
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_right_q <= dir_right_d;
            dir_down_q  <= dir_down_d;
            if (miss_left) begin
              state_q   <= SCORED;
              score_r_q <= 1'b1;
            end else if (miss_right) begin
              state_q   <= SCORED;
              score_l_q <= 1'b1;
            end
          end
        end
        SCORED: begin
          // Serve toward the player who conceded: a left score means the
          // right player missed, so the ball heads right.
          state_q     <= SERVE;
          cnt_q       <= '0;
          ball_en_q   <= 1'b1;
          ball_x_q    <= X_CTR;
          ball_y_q    <= Y_CTR;
          dir_down_q  <= 1'b1;
          dir_right_q <= score_l_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign ball_en   = ball_en_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign state_out = state_q;

endmodule
